// File: rtl/stack_seq.sv
// Stack sequencer: expands CALL/RET/INT/RETI into ordered push/pop memory transfers.
// Define STACK_BOUNDS_CHECK_EN to enable stack bounds checking and the sticky err flag.
module stack_seq #(
  parameter int          FLAG_W      = 8,
  parameter logic [31:0] STACK_BASE  = 32'h2000,
  parameter logic [31:0] STACK_LIMIT = 32'h2FFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              int_req,
  input  logic              reti_req,
  input  logic [31:0]       pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [31:0]       sp_addr,
  output logic [1:0]        sp_select,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pc_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              done,
  output logic              busy,
  output logic              err
);

  // Handshake: mem_req holds with stable mem_we/mem_addr/mem_wdata until mem_ack;
  // a transfer completes on the cycle where mem_req and mem_ack are both high.
  typedef enum logic [2:0] {
    IDLE, PUSH_PC, PUSH_FL, POP_FL, POP_PC, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic              int_q;
  logic              any_req;
  logic              viol;
  logic              push_st;
  logic              pop_st;

  assign any_req = call_req | ret_req | int_req | reti_req;
  assign push_st = (state == PUSH_PC) || (state == PUSH_FL);
  assign pop_st  = (state == POP_FL)  || (state == POP_PC);

`ifdef STACK_BOUNDS_CHECK_EN
  logic err_q;
  // sp_addr is the next free slot, so a pop at the base would underflow.
  assign viol = (push_st && (sp_addr > STACK_LIMIT)) ||
                (pop_st  && (sp_addr <= STACK_BASE));
  assign err  = err_q;
`else
  assign viol = 1'b0;
  assign err  = 1'b0;
`endif

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sp_select = 2'b00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (int_req || call_req) state_nxt = PUSH_PC;
        else if (reti_req)       state_nxt = POP_FL;
        else if (ret_req)        state_nxt = POP_PC;
      end
      PUSH_PC, PUSH_FL: begin
        if (viol) begin
          state_nxt = DONE;
        end else begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = sp_addr;
          mem_wdata = (state == PUSH_PC) ? pc_q : 32'(flags_q);
          if (mem_ack) begin
            sp_select = 2'b01;
            state_nxt = (state == PUSH_PC && int_q) ? PUSH_FL : DONE;
          end
        end
      end
      POP_FL, POP_PC: begin
        if (viol) begin
          state_nxt = DONE;
        end else begin
          mem_req  = 1'b1;
          mem_addr = sp_addr - 32'd1;
          if (mem_ack) begin
            sp_select = 2'b10;
            state_nxt = (state == POP_FL) ? POP_PC : DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= 32'h0;
      flags_q   <= '0;
      int_q     <= 1'b0;
      pc_out    <= 32'h0;
      flags_out <= '0;
`ifdef STACK_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        pc_q    <= pc_in;
        flags_q <= flags_in;
        int_q   <= int_req;
      end
      if (state == POP_FL && mem_ack && !viol) flags_out <= mem_rdata[FLAG_W-1:0];
      if (state == POP_PC && mem_ack && !viol) pc_out    <= mem_rdata;
`ifdef STACK_BOUNDS_CHECK_EN
      if (viol) err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: vector table of request sequences plus reset/busy corner cases.
// Expectations follow STACK_BOUNDS_CHECK_EN when it is defined.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call_req = 1'b0, ret_req = 1'b0, int_req = 1'b0, reti_req = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [7:0]  flags_in = 8'h0;
  logic [31:0] sp_addr;
  logic [1:0]  sp_select;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc_out;
  logic [7:0]  flags_out;
  logic        done, busy, err;

  stack_seq #(.FLAG_W(8), .STACK_BASE(32'h2000), .STACK_LIMIT(32'h2FFF)) dut (
    .clk(clk), .rst(rst),
    .call_req(call_req), .ret_req(ret_req), .int_req(int_req), .reti_req(reti_req),
    .pc_in(pc_in), .flags_in(flags_in), .sp_addr(sp_addr), .sp_select(sp_select),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_out(pc_out), .flags_out(flags_out),
    .done(done), .busy(busy), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // stack pointer model
  logic [31:0] sp_model;
  assign sp_addr = sp_model;
  always @(posedge clk) begin
    if (rst) sp_model <= 32'h2000;
    else if (sp_select == 2'b01) sp_model <= sp_model + 32'd1;
    else if (sp_select == 2'b10) sp_model <= sp_model - 32'd1;
  end

  // memory responder: ack after wait_cycles stall cycles; unwritten words read {A5A5, addr[15:0]}
  logic [31:0] mem [logic [31:0]];
  int wait_cycles = 0;
  int wcnt = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  end
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= wait_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : {16'hA5A5, mem_addr[15:0]};
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // scoreboard: expected transfers {we, addr, data}
  logic [64:0] exp_q[$];
  logic [64:0] act_x;
  int inc_cnt = 0, dec_cnt = 0, done_cnt = 0;
  logic        hold_v = 1'b0;
  logic [64:0] hold_x;

  always @(posedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("req_stable", {63'h0, mem_req, hold_x == {mem_we, mem_addr, mem_wdata}}, 64'h3);
      hold_v = mem_req && !mem_ack;
      hold_x = {mem_we, mem_addr, mem_wdata};
      if (mem_req && mem_ack) begin
        act_x = {mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata};
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected actual=%0h required=none", act_x);
        end else begin
          chk("xfer", 64'(act_x[63:0]) ^ 64'(0), 64'(exp_q[0][63:0]));
          chk("xfer_we", 64'(act_x[64]), 64'(exp_q[0][64]));
          void'(exp_q.pop_front());
        end
      end
      if (sp_select != 2'b00) chk("sp_select_on_ack", {62'h0, sp_select == 2'b11, mem_req && mem_ack}, 64'h1);
      if (sp_select == 2'b01) inc_cnt++;
      if (sp_select == 2'b10) dec_cnt++;
      if (done) done_cnt++;
    end
  end

  // vector table
  typedef struct {
    logic [3:0]  req;   // {int, call, reti, ret}
    logic [31:0] pc;
    logic [7:0]  fl;
    int          wt;
    int          n;
    logic [64:0] x0, x1;
    int          lat;
    logic [31:0] sp_after, pc_exp;
    logic [7:0]  fl_exp;
    logic        err_exp;
    int          inc, dec;
  } vec_t;

  function automatic logic [64:0] xw(input logic we, input logic [31:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  function automatic vec_t mk(input logic [3:0] req, input logic [31:0] pc, input logic [7:0] fl,
                              input int wt, input int n, input logic [64:0] x0, input logic [64:0] x1,
                              input int lat, input logic [31:0] sp, input logic [31:0] pcx,
                              input logic [7:0] flx, input logic e, input int inc, input int dec);
    vec_t v;
    v.req = req; v.pc = pc; v.fl = fl; v.wt = wt; v.n = n; v.x0 = x0; v.x1 = x1;
    v.lat = lat; v.sp_after = sp; v.pc_exp = pcx; v.fl_exp = flx; v.err_exp = e;
    v.inc = inc; v.dec = dec;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int inc0, dec0;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_cycles = v.wt;
    inc0 = inc_cnt;
    dec0 = dec_cnt;
    for (int k = 0; k < v.n; k++) exp_q.push_back(k == 0 ? v.x0 : v.x1);
    @(negedge clk);
    {int_req, call_req, reti_req, ret_req} = v.req;
    pc_in    = v.pc;
    flags_in = v.fl;
    @(posedge clk);
    #1;
    {int_req, call_req, reti_req, ret_req} = 4'b0000;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_sp"}, 64'(sp_addr), 64'(v.sp_after));
    chk({tag, "_pc_out"}, 64'(pc_out), 64'(v.pc_exp));
    chk({tag, "_flags_out"}, 64'(flags_out), 64'(v.fl_exp));
    chk({tag, "_err"}, 64'(err), 64'(v.err_exp));
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'h0);
    chk({tag, "_xfers_left"}, 64'(exp_q.size()), 64'h0);
    chk({tag, "_inc"}, 64'(inc_cnt - inc0), 64'(v.inc));
    chk({tag, "_dec"}, 64'(dec_cnt - dec0), 64'(v.dec));
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat, done0, inc0;
    logic [64:0] none;
    none = 65'h0;
    vt[0]  = mk(4'b0100, 32'h1234, 8'h00, 0, 1, xw(1, 32'h2000, 32'h1234), none,
                2, 32'h2001, 32'h0, 8'h00, 1'b0, 1, 0);
    vt[1]  = mk(4'b0001, 32'h0, 8'h00, 0, 1, xw(0, 32'h2000, 32'h1234), none,
                2, 32'h2000, 32'h1234, 8'h00, 1'b0, 0, 1);
    vt[2]  = mk(4'b1000, 32'h40, 8'hA5, 0, 2, xw(1, 32'h2000, 32'h40), xw(1, 32'h2001, 32'hA5),
                3, 32'h2002, 32'h1234, 8'h00, 1'b0, 2, 0);
    vt[3]  = mk(4'b0010, 32'h0, 8'h00, 0, 2, xw(0, 32'h2001, 32'hA5), xw(0, 32'h2000, 32'h40),
                3, 32'h2000, 32'h40, 8'hA5, 1'b0, 0, 2);
    vt[4]  = mk(4'b1101, 32'h77, 8'h11, 0, 2, xw(1, 32'h2000, 32'h77), xw(1, 32'h2001, 32'h11),
                3, 32'h2002, 32'h40, 8'hA5, 1'b0, 2, 0);
    vt[5]  = mk(4'b0011, 32'h0, 8'h00, 0, 2, xw(0, 32'h2001, 32'h11), xw(0, 32'h2000, 32'h77),
                3, 32'h2000, 32'h77, 8'h11, 1'b0, 0, 2);
    vt[6]  = mk(4'b0100, 32'hCAFE, 8'h00, 2, 1, xw(1, 32'h2000, 32'hCAFE), none,
                4, 32'h2001, 32'h77, 8'h11, 1'b0, 1, 0);
    vt[7]  = mk(4'b1000, 32'h100, 8'h3C, 1, 2, xw(1, 32'h2001, 32'h100), xw(1, 32'h2002, 32'h3C),
                5, 32'h2003, 32'h77, 8'h11, 1'b0, 2, 0);
    vt[8]  = mk(4'b0010, 32'h0, 8'h00, 2, 2, xw(0, 32'h2002, 32'h3C), xw(0, 32'h2001, 32'h100),
                7, 32'h2001, 32'h100, 8'h3C, 1'b0, 0, 2);
    vt[9]  = mk(4'b0001, 32'h0, 8'h00, 0, 1, xw(0, 32'h2000, 32'hCAFE), none,
                2, 32'h2000, 32'hCAFE, 8'h3C, 1'b0, 0, 1);
`ifdef STACK_BOUNDS_CHECK_EN
    vt[10] = mk(4'b0001, 32'h0, 8'h00, 3, 0, none, none,
                2, 32'h2000, 32'hCAFE, 8'h3C, 1'b1, 0, 0);
`else
    vt[10] = mk(4'b0001, 32'h0, 8'h00, 3, 1, xw(0, 32'h1FFF, 32'hA5A51FFF), none,
                5, 32'h1FFF, 32'hA5A51FFF, 8'h3C, 1'b0, 0, 1);
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sp_select", 64'(sp_select), 64'h0);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_pc_out", 64'(pc_out), 64'h0);
    chk("rst_flags_out", 64'(flags_out), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vt[i], i);

    // err is sticky until reset
    repeat (3) @(negedge clk);
`ifdef STACK_BOUNDS_CHECK_EN
    chk("err_sticky", 64'(err), 64'h1);
`else
    chk("err_sticky", 64'(err), 64'h0);
`endif
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'h0);
    chk("sp_after_reset", 64'(sp_addr), 64'h2000);

    // call_req held while busy: only one push, captured pc is the sampled one
    wait_cycles = 2;
    done0 = done_cnt;
    inc0  = inc_cnt;
    exp_q.push_back(xw(1, 32'h2000, 32'h5555));
    @(negedge clk);
    call_req = 1'b1;
    pc_in    = 32'h5555;
    @(posedge clk);
    #1;
    pc_in = 32'h6666;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 3) call_req = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    call_req = 1'b0;
    chk("busy_call_latency", 64'(lat), 64'd4);
    repeat (4) @(negedge clk);
    chk("busy_call_done_cnt", 64'(done_cnt - done0), 64'd1);
    chk("busy_call_inc_cnt", 64'(inc_cnt - inc0), 64'd1);
    chk("busy_call_xfers_left", 64'(exp_q.size()), 64'h0);
    chk("busy_call_idle", 64'(busy), 64'h0);
    exp_q.delete();
    do_reset();

    // reset during PUSH_FL wait abandons the frame
    wait_cycles = 0;
    done0 = done_cnt;
    inc0  = inc_cnt;
    exp_q.push_back(xw(1, 32'h2000, 32'h9));
    @(negedge clk);
    int_req  = 1'b1;
    pc_in    = 32'h9;
    flags_in = 8'h02;
    @(posedge clk);
    #1;
    int_req = 1'b0;
    @(posedge clk);
    #1;
    wait_cycles = 50;
    @(negedge clk);
    chk("pushfl_busy", 64'(busy), 64'h1);
    chk("pushfl_req", {62'h0, mem_req, mem_we}, 64'h3);
    chk("pushfl_addr", 64'(mem_addr), 64'h2001);
    chk("pushfl_wdata", 64'(mem_wdata), 64'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_mem_req", 64'(mem_req), 64'h0);
    repeat (5) @(negedge clk);
    chk("abort_done_cnt", 64'(done_cnt - done0), 64'd0);
    chk("abort_inc_cnt", 64'(inc_cnt - inc0), 64'd1);
    chk("abort_xfers_left", 64'(exp_q.size()), 64'h0);
    chk("abort_sp", 64'(sp_addr), 64'h2000);
    wait_cycles = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
